// File: rtl/exe_ctrl_pkg.sv
// Shared constants and state encoding for the execute-stage sequencing controller.
package exe_ctrl_pkg;

  localparam int ARCH_LEN_DEF    = 32;
  localparam int MUL_LATENCY_DEF = 4;
  localparam int PERF_W_DEF      = 32;
  localparam int MUL_CNT_W       = 4;

  typedef enum logic [1:0] {
    RUN,
    MUL_BUSY,
    MEM_WAIT
  } exe_ctrl_state_t;

endpackage

// File: rtl/exe_ctrl_if.sv
// Pipeline-control bundle between the execute stage datapath and exe_ctrl.
interface exe_ctrl_if #(
  parameter int ARCH_LEN = 32,
  parameter int PERF_W   = 32
);
  logic [4:0]          id_rs1_in;
  logic [4:0]          id_rs2_in;
  logic                id_use_rs1_in;
  logic                id_use_rs2_in;
  logic                exe_valid_in;
  logic                exe_is_load_in;
  logic                exe_is_mul_in;
  logic [4:0]          exe_rd_in;
  logic                kill_exe_in;
  logic [ARCH_LEN-1:0] pc_br_tk_in;
  logic                mem_busy_in;
  logic                stall_if_out;
  logic                stall_id_out;
  logic                stall_exe_out;
  logic                flush_if_out;
  logic                flush_exe_out;
  logic                mul_done_out;
  logic                redirect_valid_out;
  logic [ARCH_LEN-1:0] redirect_pc_out;
  logic [PERF_W-1:0]   stall_cnt_out;

  modport master (
    output id_rs1_in, id_rs2_in, id_use_rs1_in, id_use_rs2_in, exe_valid_in,
           exe_is_load_in, exe_is_mul_in, exe_rd_in, kill_exe_in, pc_br_tk_in,
           mem_busy_in,
    input  stall_if_out, stall_id_out, stall_exe_out, flush_if_out, flush_exe_out,
           mul_done_out, redirect_valid_out, redirect_pc_out, stall_cnt_out
  );

  modport slave (
    input  id_rs1_in, id_rs2_in, id_use_rs1_in, id_use_rs2_in, exe_valid_in,
           exe_is_load_in, exe_is_mul_in, exe_rd_in, kill_exe_in, pc_br_tk_in,
           mem_busy_in,
    output stall_if_out, stall_id_out, stall_exe_out, flush_if_out, flush_exe_out,
           mul_done_out, redirect_valid_out, redirect_pc_out, stall_cnt_out
  );
endinterface

// File: rtl/exe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/exe_ctrl.sv
// Execute-stage sequencing: MUL occupancy, memory-wait freeze, load-use bubble,
// branch kill with registered redirect, and a stall-cycle performance counter.
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int ARCH_LEN    = ARCH_LEN_DEF,
  parameter int PERF_W      = PERF_W_DEF
) (
  input logic       clk,
  input logic       rst,
  exe_ctrl_if.slave bus
);

  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);

  exe_ctrl_state_t      state, state_d;
  logic [MUL_CNT_W-1:0] cnt, cnt_d;
  logic                 run_like;
  logic                 stall;
  logic                 mul_done;
  logic                 kill_take;
  logic                 lu_stall;
  logic                 load_use;
  logic                 redirect_valid_q;
  logic [ARCH_LEN-1:0]  redirect_pc_q;

  assign load_use = bus.exe_valid_in && bus.exe_is_load_in && (bus.exe_rd_in != 5'd0) &&
                    ((bus.id_use_rs1_in && (bus.id_rs1_in == bus.exe_rd_in)) ||
                     (bus.id_use_rs2_in && (bus.id_rs2_in == bus.exe_rd_in)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    run_like = 1'b0;
    stall    = 1'b0;
    mul_done = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_busy_in) begin
          stall   = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          run_like = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (bus.mem_busy_in) begin
          stall   = 1'b1;
          state_d = MEM_WAIT;
        end else if (cnt > MUL_CNT_W'(1)) begin
          stall = 1'b1;
          cnt_d = cnt - MUL_CNT_W'(1);
        end else begin
          mul_done = 1'b1;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_busy_in) begin
          stall = 1'b1;
        end else if (cnt != '0) begin
          // The interrupted MUL resumes next cycle with its count untouched.
          stall   = 1'b1;
          state_d = MUL_BUSY;
        end else begin
          run_like = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_like && bus.exe_valid_in && bus.exe_is_mul_in) begin
      if (MUL_LATENCY > 1) begin
        stall   = 1'b1;
        cnt_d   = MUL_LOAD;
        state_d = MUL_BUSY;
      end else begin
        mul_done = 1'b1;
      end
    end
  end

  // A kill waits while execute is held; it outranks the load-use bubble.
  assign kill_take = bus.kill_exe_in && !stall;
  assign lu_stall  = run_like && !stall && !bus.kill_exe_in && load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RUN;
      cnt              <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      redirect_valid_q <= kill_take;
      if (kill_take) begin
        redirect_pc_q <= bus.pc_br_tk_in;
      end
    end
  end

  assign bus.stall_if_out       = stall || lu_stall;
  assign bus.stall_id_out       = stall || lu_stall;
  assign bus.stall_exe_out      = stall;
  assign bus.flush_if_out       = kill_take;
  assign bus.flush_exe_out      = kill_take || lu_stall;
  assign bus.mul_done_out       = mul_done;
  assign bus.redirect_valid_out = redirect_valid_q;
  assign bus.redirect_pc_out    = redirect_pc_q;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.stall_if_out),
    .count (bus.stall_cnt_out)
  );

endmodule

// File: tb/tb_exe_ctrl.sv
// Bench for exe_ctrl: a cycle model checks the main instance every cycle; a second
// instance (MUL_LATENCY=1, PERF_W=4) covers the single-cycle MUL and counter saturation.
module tb_exe_ctrl;
  import exe_ctrl_pkg::*;

  localparam int L = 4;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic        valid;
    logic        is_load;
    logic        is_mul;
    logic [4:0]  rd;
    logic        kill;
    logic [31:0] pc;
    logic        mem_busy;
  } in_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exe_ctrl_if #(.ARCH_LEN(32), .PERF_W(32)) bm ();
  exe_ctrl_if #(.ARCH_LEN(32), .PERF_W(4))  bs ();

  exe_ctrl #(.MUL_LATENCY(L), .ARCH_LEN(32), .PERF_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bm.slave)
  );

  exe_ctrl #(.MUL_LATENCY(1), .ARCH_LEN(32), .PERF_W(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bs.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  task automatic apply(input in_t v);
    bm.id_rs1_in = v.rs1;  bm.id_rs2_in = v.rs2;
    bm.id_use_rs1_in = v.use1;  bm.id_use_rs2_in = v.use2;
    bm.exe_valid_in = v.valid;  bm.exe_is_load_in = v.is_load;
    bm.exe_is_mul_in = v.is_mul;  bm.exe_rd_in = v.rd;
    bm.kill_exe_in = v.kill;  bm.pc_br_tk_in = v.pc;  bm.mem_busy_in = v.mem_busy;
    bs.id_rs1_in = v.rs1;  bs.id_rs2_in = v.rs2;
    bs.id_use_rs1_in = v.use1;  bs.id_use_rs2_in = v.use2;
    bs.exe_valid_in = v.valid;  bs.exe_is_load_in = v.is_load;
    bs.exe_is_mul_in = v.is_mul;  bs.exe_rd_in = v.rd;
    bs.kill_exe_in = v.kill;  bs.pc_br_tk_in = v.pc;  bs.mem_busy_in = v.mem_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: MUL owes a number of cycles until its result; a memory wait freezes that debt,
  // and the cycle memory comes back is still held while a MUL is outstanding.
  int          m_owed   = 0;
  bit          m_in_mem = 1'b0;
  bit          m_rv     = 1'b0;
  logic [31:0] m_rpc    = '0;
  longint      m_scnt   = 0;
  bit          e_stall, e_lu, e_done, e_kill, free, lu_cond;

  always @(negedge clk) begin
    if (rst) begin
      m_owed = 0;  m_in_mem = 1'b0;  m_rv = 1'b0;  m_rpc = '0;  m_scnt = 0;
      check("rst_stall_if", bm.stall_if_out, 0);
      check("rst_flush_exe", bm.flush_exe_out, 0);
      check("rst_redirect_valid", bm.redirect_valid_out, 0);
      check("rst_stall_cnt", bm.stall_cnt_out, 0);
    end else begin
      check("redirect_valid", bm.redirect_valid_out, m_rv);
      check("redirect_pc", bm.redirect_pc_out, m_rpc);
      check("stall_cnt", bm.stall_cnt_out, m_scnt);

      e_stall = 1'b0;  e_done = 1'b0;  free = 1'b0;
      if (bm.mem_busy_in) begin
        e_stall  = 1'b1;
        m_in_mem = 1'b1;
      end else if (m_in_mem && m_owed > 0) begin
        e_stall  = 1'b1;
        m_in_mem = 1'b0;
      end else if (m_owed > 1) begin
        e_stall = 1'b1;
        m_owed--;
      end else if (m_owed == 1) begin
        e_done = 1'b1;
        m_owed = 0;
      end else begin
        m_in_mem = 1'b0;
        free     = 1'b1;
      end
      if (free && bm.exe_valid_in && bm.exe_is_mul_in) begin
        if (L > 1) begin
          e_stall = 1'b1;
          m_owed  = L - 1;
        end else begin
          e_done = 1'b1;
        end
      end
      lu_cond = bm.exe_valid_in && bm.exe_is_load_in && bm.exe_rd_in != 0 &&
                ((bm.id_use_rs1_in && bm.id_rs1_in == bm.exe_rd_in) ||
                 (bm.id_use_rs2_in && bm.id_rs2_in == bm.exe_rd_in));
      e_kill = bm.kill_exe_in && !e_stall;
      e_lu   = free && !e_stall && !bm.kill_exe_in && lu_cond;

      check("stall_if", bm.stall_if_out, e_stall | e_lu);
      check("stall_id", bm.stall_id_out, e_stall | e_lu);
      check("stall_exe", bm.stall_exe_out, e_stall);
      check("flush_if", bm.flush_if_out, e_kill);
      check("flush_exe", bm.flush_exe_out, e_kill | e_lu);
      check("mul_done", bm.mul_done_out, e_done);

      m_rv = e_kill;
      if (e_kill) m_rpc = bm.pc_br_tk_in;
      if ((e_stall || e_lu) && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t v;
    apply(idle());
    #1;
    check("init_stall_cnt", bm.stall_cnt_out, 0);
    check("init_redirect_pc", bm.redirect_pc_out, 0);
    check("init_small_cnt", bs.stall_cnt_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back MULs: stalls for three cycles, done on the fourth, restart on the fifth.
    v = idle();  v.valid = 1;  v.is_mul = 1;
    apply(v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mul_done_%0d", i), bm.mul_done_out, (i == 3 || i == 7));
      check($sformatf("mul_stall_%0d", i), bm.stall_exe_out, !(i == 3 || i == 7));
      if (i == 0) begin
        check("l1_mul_done", bs.mul_done_out, 1);
        check("l1_no_stall", bs.stall_if_out, 0);
      end
      if (i == 4) check("mul_stall_cnt_3", bm.stall_cnt_out, 3);
      tick();
    end
    apply(idle());
    @(negedge clk);
    check("mul_stall_cnt_6", bm.stall_cnt_out, 6);
    tick();

    // Load-use on rs1, then the bubble cycle, rs2 match, unused operand, and x0.
    v = idle();  v.valid = 1;  v.is_load = 1;  v.rd = 5;
    v.use1 = 1;  v.rs1 = 5;  v.use2 = 1;  v.rs2 = 1;
    apply(v);
    @(negedge clk);
    check("lu_stall_if", bm.stall_if_out, 1);
    check("lu_flush_exe", bm.flush_exe_out, 1);
    check("lu_stall_exe", bm.stall_exe_out, 0);
    tick();
    v.valid = 0;
    apply(v);
    @(negedge clk);
    check("lu_bubble_clean", bm.stall_if_out, 0);
    tick();
    v.valid = 1;  v.rs1 = 3;  v.rs2 = 5;
    apply(v);
    @(negedge clk);
    check("lu_rs2_stall_id", bm.stall_id_out, 1);
    tick();
    v.rs1 = 5;  v.rs2 = 1;  v.use1 = 0;
    apply(v);
    @(negedge clk);
    check("lu_unused_rs1", bm.stall_if_out, 0);
    tick();
    v.rd = 0;  v.rs1 = 0;  v.use1 = 1;
    apply(v);
    @(negedge clk);
    check("lu_x0", bm.flush_exe_out, 0);
    tick();

    // Taken branch: same-cycle flush, one-cycle registered redirect.
    v = idle();  v.kill = 1;  v.pc = 32'h0000_0100;
    apply(v);
    @(negedge clk);
    check("kill_flush_if", bm.flush_if_out, 1);
    check("kill_flush_exe", bm.flush_exe_out, 1);
    tick();
    apply(idle());
    @(negedge clk);
    check("redir_valid", bm.redirect_valid_out, 1);
    check("redir_pc", bm.redirect_pc_out, 32'h100);
    tick();
    @(negedge clk);
    check("redir_one_cycle", bm.redirect_valid_out, 0);
    tick();
    v = idle();  v.kill = 1;  v.pc = 32'h0000_0200;
    v.valid = 1;  v.is_load = 1;  v.rd = 7;  v.use1 = 1;  v.rs1 = 7;
    apply(v);
    @(negedge clk);
    check("kill_over_lu", bm.stall_if_out, 0);
    tick();
    apply(idle());
    @(negedge clk);
    check("redir_pc_2", bm.redirect_pc_out, 32'h200);
    tick();

    // Memory wait for three cycles while the MUL counter sits at 2.
    for (int i = 0; i < 8; i++) begin
      v = idle();  v.valid = 1;  v.is_mul = 1;  v.mem_busy = (i >= 2 && i <= 4);
      apply(v);
      @(negedge clk);
      check($sformatf("memmul_done_%0d", i), bm.mul_done_out, (i == 7));
      check($sformatf("memmul_stall_%0d", i), bm.stall_if_out, (i < 7));
      tick();
    end
    apply(idle());
    tick();

    // Kill presented during a memory wait is taken when the wait ends.
    v = idle();  v.kill = 1;  v.pc = 32'h0000_0300;  v.mem_busy = 1;
    for (int i = 0; i < 2; i++) begin
      apply(v);
      @(negedge clk);
      check("kill_mem_no_flush", bm.flush_if_out, 0);
      tick();
    end
    v.mem_busy = 0;
    apply(v);
    @(negedge clk);
    check("kill_after_mem_flush", bm.flush_if_out, 1);
    check("kill_after_mem_stall", bm.stall_if_out, 0);
    tick();
    apply(idle());
    @(negedge clk);
    check("kill_after_mem_redir", bm.redirect_pc_out, 32'h300);
    check("small_cnt_7", bs.stall_cnt_out, 7);
    tick();

    // Long stall saturates the 4-bit counter.
    v = idle();  v.mem_busy = 1;
    apply(v);
    repeat (20) tick();
    apply(idle());
    @(negedge clk);
    check("small_cnt_sat", bs.stall_cnt_out, 15);
    tick();

    // Reset asserted with the MUL counter at 2.
    v = idle();  v.valid = 1;  v.is_mul = 1;
    apply(v);
    tick();
    tick();
    #2;
    apply(idle());
    rst = 1'b1;
    #1;
    check("arst_stall_exe", bm.stall_exe_out, 0);
    check("arst_stall_cnt", bm.stall_cnt_out, 0);
    check("arst_small_cnt", bs.stall_cnt_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bm.stall_if_out, 0);
    tick();
    v = idle();  v.valid = 1;  v.is_mul = 1;
    apply(v);
    repeat (4) tick();
    apply(idle());
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
